// File: rtl/uart_cmd_decoder_if.sv
// Byte-strobe input and decoded control outputs of the UART command decoder.
// rx_done_tick is a valid-only strobe: the decoder is always ready, so every high cycle is one accepted byte.
interface uart_cmd_decoder_if #(
  parameter int DATA_BIT = 16
);
  logic [7:0]          data;
  logic                rx_done_tick;
  logic [DATA_BIT-1:0] output_pattern;
  logic [DATA_BIT-1:0] freq_pattern;
  logic [3:0]          sel_out;
  logic                mode;
  logic                start;
  logic                stop;
  logic                done_tick;

  modport master (
    output data, rx_done_tick,
    input  output_pattern, freq_pattern, sel_out, mode, start, stop, done_tick
  );

  modport slave (
    input  data, rx_done_tick,
    output output_pattern, freq_pattern, sel_out, mode, start, stop, done_tick
  );
endinterface

// File: rtl/uart_cmd_decoder.sv
// Parses {OP,SEL} command frames from a UART byte stream and drives pattern/control registers.
// Frames are applied atomically one clock after the final byte strobe.
module uart_cmd_decoder #(
  parameter int DATA_BIT = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  uart_cmd_decoder_if.slave   bus,
  output logic                dbg_state
);
  localparam int NBYTE = DATA_BIT / 8;
  localparam int CW    = (NBYTE > 1) ? $clog2(NBYTE) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    DATA = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [DATA_BIT-1:0] shadow_q, shadow_d;
  logic [7:0]          cmd_q, cmd_d;
  logic [DATA_BIT-1:0] out_pat_q, out_pat_d;
  logic [DATA_BIT-1:0] freq_q, freq_d;
  logic [3:0]          sel_q, sel_d;
  logic                mode_q, mode_d;
  logic                start_q, start_d;
  logic                stop_q, stop_d;
  logic                done_q, done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shadow_q  <= '0;
      cmd_q     <= '0;
      out_pat_q <= '0;
      freq_q    <= '0;
      sel_q     <= '0;
      mode_q    <= 1'b0;
      start_q   <= 1'b0;
      stop_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shadow_q  <= shadow_d;
      cmd_q     <= cmd_d;
      out_pat_q <= out_pat_d;
      freq_q    <= freq_d;
      sel_q     <= sel_d;
      mode_q    <= mode_d;
      start_q   <= start_d;
      stop_q    <= stop_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shadow_d  = shadow_q;
    cmd_d     = cmd_q;
    out_pat_d = out_pat_q;
    freq_d    = freq_q;
    sel_d     = sel_q;
    mode_d    = mode_q;
    start_d   = 1'b0;
    stop_d    = 1'b0;
    done_d    = 1'b0;

    if (bus.rx_done_tick) begin
      unique case (state_q)
        IDLE: begin
          // Unknown opcodes fall through the default and are silently dropped.
          case (bus.data[7:4])
            4'd1: begin start_d = 1'b1; sel_d = bus.data[3:0]; done_d = 1'b1; end
            4'd2: begin stop_d  = 1'b1; sel_d = bus.data[3:0]; done_d = 1'b1; end
            4'd3: begin mode_d  = 1'b0; sel_d = bus.data[3:0]; done_d = 1'b1; end
            4'd4: begin mode_d  = 1'b1; sel_d = bus.data[3:0]; done_d = 1'b1; end
            4'd5, 4'd6: begin
              cmd_d   = bus.data;
              cnt_d   = '0;
              state_d = DATA;
            end
            default: ;
          endcase
        end
        DATA: begin
          for (int k = 0; k < NBYTE; k++) begin
            if (cnt_q == CW'(k)) shadow_d[8*k +: 8] = bus.data;
          end
          if (cnt_q == CW'(NBYTE - 1)) begin
            // Shadow including this byte is committed in one step, so no partial frame is visible.
            if (cmd_q[7:4] == 4'd5) out_pat_d = shadow_d;
            else                    freq_d    = shadow_d;
            sel_d   = cmd_q[3:0];
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.output_pattern = out_pat_q;
  assign bus.freq_pattern   = freq_q;
  assign bus.sel_out        = sel_q;
  assign bus.mode           = mode_q;
  assign bus.start          = start_q;
  assign bus.stop           = stop_q;
  assign bus.done_tick      = done_q;
  assign dbg_state          = state_q;
endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed bench for uart_cmd_decoder: byte strobes driven on the falling edge, outputs checked there too.
module tb_uart_cmd_decoder;
  logic clk;
  logic rst_n;
  logic dbg_state;
  int   checks;
  int   failures;

  uart_cmd_decoder_if #(.DATA_BIT(16)) bus ();

  uart_cmd_decoder #(.DATA_BIT(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Holds the strobe for n cycles; returns at the falling edge after the last sampled byte.
  task automatic send_hold(input logic [7:0] b, input int n);
    @(negedge clk);
    bus.data         = b;
    bus.rx_done_tick = 1'b1;
    repeat (n) @(negedge clk);
    bus.rx_done_tick = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    send_hold(b, 1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_done"},  32'(bus.done_tick), 32'd0);
    check({tag, "_start"}, 32'(bus.start),     32'd0);
    check({tag, "_stop"},  32'(bus.stop),      32'd0);
  endtask

  logic [7:0] rb;
  logic       in_frame;
  int         fcnt;
  logic       exp_done;

  initial begin
    checks = 0;
    failures = 0;
    bus.data = 8'h00;
    bus.rx_done_tick = 1'b0;
    rst_n = 1'b0;

    // 1: reset
    repeat (2) @(negedge clk);
    check("rst_out_pat",  32'(bus.output_pattern), 32'h0);
    check("rst_freq_pat", 32'(bus.freq_pattern),   32'h0);
    check("rst_sel",      32'(bus.sel_out),        32'h0);
    check("rst_mode",     32'(bus.mode),           32'h0);
    check_idle_outputs("rst");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_outputs("post_rst");
    check("post_rst_state", 32'(dbg_state), 32'd0);

    // 2: LOAD_OUT 0x1234 to channel 3
    send(8'h53);
    check("lo_b1_done",  32'(bus.done_tick),      32'd0);
    check("lo_b1_pat",   32'(bus.output_pattern), 32'h0);
    check("lo_b1_state", 32'(dbg_state),          32'd1);
    send(8'h34);
    check("lo_b2_done", 32'(bus.done_tick),      32'd0);
    check("lo_b2_pat",  32'(bus.output_pattern), 32'h0);
    check("lo_b2_sel",  32'(bus.sel_out),        32'h0);
    send(8'h12);
    check("lo_done", 32'(bus.done_tick),      32'd1);
    check("lo_pat",  32'(bus.output_pattern), 32'h1234);
    check("lo_sel",  32'(bus.sel_out),        32'h3);
    @(negedge clk);
    check("lo_done_1cyc", 32'(bus.done_tick), 32'd0);

    // 3: LOAD_FREQ 0xABCD to channel A
    send(8'h6A);
    send(8'hCD);
    check("lf_b2_freq", 32'(bus.freq_pattern), 32'h0);
    send(8'hAB);
    check("lf_done",     32'(bus.done_tick),      32'd1);
    check("lf_freq",     32'(bus.freq_pattern),   32'hABCD);
    check("lf_sel",      32'(bus.sel_out),        32'hA);
    check("lf_out_kept", 32'(bus.output_pattern), 32'h1234);

    // 4: mode set/clear
    send(8'h41);
    check("m1_mode", 32'(bus.mode),      32'd1);
    check("m1_done", 32'(bus.done_tick), 32'd1);
    check("m1_sel",  32'(bus.sel_out),   32'h1);
    send(8'h30);
    check("m0_mode", 32'(bus.mode),      32'd0);
    check("m0_done", 32'(bus.done_tick), 32'd1);
    check("m0_sel",  32'(bus.sel_out),   32'h0);

    // 5: start / stop pulses
    send(8'h12);
    check("st_start", 32'(bus.start),     32'd1);
    check("st_done",  32'(bus.done_tick), 32'd1);
    check("st_sel",   32'(bus.sel_out),   32'h2);
    @(negedge clk);
    check_idle_outputs("st_after");
    send(8'h27);
    check("sp_stop", 32'(bus.stop),      32'd1);
    check("sp_done", 32'(bus.done_tick), 32'd1);
    check("sp_sel",  32'(bus.sel_out),   32'h7);
    @(negedge clk);
    check_idle_outputs("sp_after");

    // 6: invalid opcode, mid-frame reset, fresh frame
    send(8'hF0);
    check("inv_done",  32'(bus.done_tick), 32'd0);
    check("inv_sel",   32'(bus.sel_out),   32'h7);
    check("inv_state", 32'(dbg_state),     32'd0);
    send(8'h55);
    send(8'h11);
    rst_n = 1'b0;
    @(negedge clk);
    check("mrst_pat",   32'(bus.output_pattern), 32'h0);
    check("mrst_freq",  32'(bus.freq_pattern),   32'h0);
    check("mrst_state", 32'(dbg_state),          32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    send(8'h51);
    send(8'h22);
    send(8'h33);
    check("fr_done", 32'(bus.done_tick),      32'd1);
    check("fr_pat",  32'(bus.output_pattern), 32'h3322);
    check("fr_sel",  32'(bus.sel_out),        32'h1);

    // Strobe held two cycles supplies both payload bytes
    send(8'h54);
    send_hold(8'h77, 2);
    check("hold_done", 32'(bus.done_tick),      32'd1);
    check("hold_pat",  32'(bus.output_pattern), 32'h7777);
    check("hold_sel",  32'(bus.sel_out),        32'h4);

    // 7: eleven random bytes; done only when a frame completes
    in_frame = 1'b0;
    fcnt = 0;
    for (int i = 0; i < 11; i++) begin
      rb = 8'($urandom_range(0, 255));
      if (i % 3 == 0) rb[7:4] = 4'($urandom_range(1, 6));
      exp_done = 1'b0;
      if (!in_frame) begin
        if (rb[7:4] >= 4'd1 && rb[7:4] <= 4'd4) exp_done = 1'b1;
        else if (rb[7:4] == 4'd5 || rb[7:4] == 4'd6) begin
          in_frame = 1'b1;
          fcnt = 0;
        end
      end else begin
        fcnt++;
        if (fcnt == 2) begin
          exp_done = 1'b1;
          in_frame = 1'b0;
        end
      end
      send(rb);
      check("rnd_done", 32'(bus.done_tick), 32'(exp_done));
      check("rnd_nox", 32'($isunknown({bus.output_pattern, bus.freq_pattern, bus.sel_out,
                                        bus.mode, bus.start, bus.stop, bus.done_tick})), 32'd0);
    end

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
